// File: rtl/bpt_update_ctrl.sv
// BPT update sequencer: initialization sweep, then two-requester update FIFO drained one per cycle.
// Optional `BPT_UPD_BYPASS_EN: an empty FIFO forwards br0 to the BPT port in the same cycle.
module bpt_update_ctrl #(
  parameter int ENTRIES     = 256,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_PASSES = 2
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          br0_valid,
  input  logic [31:0]                   br0_pc,
  input  logic                          br0_taken,
  output logic                          br0_ready,
  input  logic                          br1_valid,
  input  logic [31:0]                   br1_pc,
  input  logic                          br1_taken,
  output logic                          br1_ready,
  input  logic                          reinit_req,
  output logic [31:0]                   pc_res,
  output logic                          taken_res,
  output logic                          enable_res,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PASS_W = (INIT_PASSES > 1) ? $clog2(INIT_PASSES) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(ENTRIES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(INIT_PASSES - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_M2  = CNT_W'(FIFO_DEPTH - 2);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [PASS_W-1:0]  pass;
  logic [31:0]        mem_pc    [FIFO_DEPTH];
  logic               mem_taken [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr1;
  logic [CNT_W-1:0]   count;
  logic               push0, push1, enq0, pop, bypass;

  assign fifo_count = count;
  assign wr_ptr1    = wr_ptr + PTR_W'(1);
  assign enq0       = push0 && !bypass;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    br0_ready  = 1'b0;
    br1_ready  = 1'b0;
    enable_res = 1'b0;
    pc_res     = '0;
    taken_res  = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;
    case (state)
      S_INIT: begin
        busy       = 1'b1;
        enable_res = 1'b1;
        pc_res     = {{(30-IDX_W){1'b0}}, idx, 2'b00};
        if (idx == IDX_LAST && pass == PASS_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        // Ready depends only on registered count, never on valid.
        br0_ready = (count < DEPTH_C) && !reinit_req;
        br1_ready = (count <= DEPTH_M2) && !reinit_req;
        push0     = br0_valid && br0_ready;
        push1     = br1_valid && br1_ready;
        if (reinit_req) begin
          state_next = S_INIT;
        end else if (count != '0) begin
          pop        = 1'b1;
          enable_res = 1'b1;
          pc_res     = mem_pc[rd_ptr];
          taken_res  = mem_taken[rd_ptr];
        end
`ifdef BPT_UPD_BYPASS_EN
        else if (push0) begin
          bypass     = 1'b1;
          enable_res = 1'b1;
          pc_res     = br0_pc;
          taken_res  = br0_taken;
        end
`endif
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idx    <= '0;
      pass   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (state == S_INIT) begin
      if (idx == IDX_LAST) begin
        idx  <= '0;
        pass <= (pass == PASS_LAST) ? '0 : pass + PASS_W'(1);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end else if (reinit_req) begin
      idx    <= '0;
      pass   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(enq0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(enq0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  // br0 lands first so it is older than a same-cycle br1.
  always_ff @(posedge CLK) begin
    if (enq0) begin
      mem_pc[wr_ptr]    <= br0_pc;
      mem_taken[wr_ptr] <= br0_taken;
    end
    if (push1) begin
      mem_pc[enq0 ? wr_ptr1 : wr_ptr]    <= br1_pc;
      mem_taken[enq0 ? wr_ptr1 : wr_ptr] <= br1_taken;
    end
  end

endmodule
